// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem requests, 2-entry queue.
// Optional FETCH_PERF_EN adds a saturating decode-bubble counter.
module fetch_unit #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            id_ready
`ifdef FETCH_PERF_EN
  , output logic [31:0]   perf_bubble_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ent_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            outstanding;
  logic            drop;
  logic [1:0]      count;
  ent_t            q0;
  ent_t            q1;
  ent_t            new_e;
  logic            resp;
  logic            push;
  logic            pop;
  logic            accept;
  logic            unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign resp   = imem_rvalid && outstanding;
  assign push   = resp && !drop && !redirect_valid;
  assign pop    = if_valid && id_ready && !redirect_valid;
  assign accept = imem_req && imem_ready;
  assign new_e  = '{pc: req_pc, instr: imem_rdata};

  assign imem_req = !reset && !redirect_valid && !outstanding &&
    (({1'b0, count} + {2'b00, outstanding}) < 3'd2);
  assign imem_addr = pc;

  assign if_valid = (count != 2'd0);
  assign if_pc    = q0.pc;
  assign if_instr = q0.instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      count       <= 2'd0;
      q0          <= '0;
      q1          <= '0;
    end else if (redirect_valid) begin
      pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      count <= 2'd0;
      if (resp)
        outstanding <= 1'b0;
      // a response still in flight belongs to the old path
      drop <= outstanding && !imem_rvalid;
    end else begin
      if (accept) begin
        outstanding <= 1'b1;
        req_pc      <= pc;
        pc          <= pc + XLEN'(4);
      end
      if (resp) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0)
            q0 <= new_e;
          else
            q1 <= new_e;
          count <= count + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q0 <= new_e;
          end else begin
            q0 <= q1;
            q1 <= new_e;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)
      perf_bubble_cnt <= 32'd0;
    else if (id_ready && !if_valid && perf_bubble_cnt != 32'hFFFF_FFFF)
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ordering, stall, redirect/drop, PC wrap.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        mrv2;
  logic [31:0] maddr2;
  logic        if_valid2;
  logic [31:0] if_pc2;
  logic [31:0] if_instr2;
`ifdef FETCH_PERF_EN
  logic [31:0] perf;
  logic [31:0] perf2;
`endif

  int          total;
  int          bad;
  int          lat;
  int          mcnt;
  logic        mrv;
  logic [31:0] maddr;
  int          cyc;

  logic [31:0] got_pc [16];
  logic [31:0] got_ins [16];
  int          got_cyc [16];
  int          nget;
  logic [31:0] got2_pc [16];
  int          nget2;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr),
    .id_ready(id_ready)
`ifdef FETCH_PERF_EN
    , .perf_bubble_cnt(perf)
`endif
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req2),
    .imem_addr(imem_addr2),
    .imem_ready(1'b1),
    .imem_rvalid(mrv2),
    .imem_rdata(maddr2 ^ 32'h13),
    .redirect_valid(1'b0),
    .redirect_pc(32'h0),
    .if_valid(if_valid2),
    .if_pc(if_pc2),
    .if_instr(if_instr2),
    .id_ready(1'b1)
`ifdef FETCH_PERF_EN
    , .perf_bubble_cnt(perf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rvalid = mrv;
  assign imem_rdata  = maddr ^ 32'h13;

  // memory model: response lat cycles after acceptance
  always @(posedge clk) begin
    if (reset) begin
      mcnt <= 0;
      mrv  <= 1'b0;
    end else if (imem_req && imem_ready) begin
      maddr <= imem_addr;
      mrv   <= (lat == 1);
      mcnt  <= lat - 1;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      mrv  <= (mcnt == 1);
    end else begin
      mrv <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      mrv2 <= 1'b0;
    end else begin
      mrv2 <= imem_req2;
      if (imem_req2)
        maddr2 <= imem_addr2;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      nget  <= 0;
      nget2 <= 0;
    end else begin
      if (if_valid && id_ready && !redirect_valid && nget < 16) begin
        got_pc[nget]  <= if_pc;
        got_ins[nget] <= if_instr;
        got_cyc[nget] <= cyc;
        nget <= nget + 1;
      end
      if (if_valid2 && nget2 < 16) begin
        got2_pc[nget2] <= if_pc2;
        nget2 <= nget2 + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int l, input logic r, input logic idr);
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    lat = l;
    imem_ready = r;
    id_ready = idr;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc2", if_pc2, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    reset = 1'b1;
    imem_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;
    lat = 1;
    for (int i = 0; i < 16; i++) begin
      got_pc[i] = '0;
      got_ins[i] = '0;
      got_cyc[i] = 0;
      got2_pc[i] = '0;
    end

    // streaming, zero-wait memory; dut2 checks PC wrap
    do_reset(1, 1'b1, 1'b1);
    #1;
    chk("s_req0", {31'b0, imem_req}, 32'd1);
    chk("s_addr0", imem_addr, 32'h0);
    repeat (7) @(negedge clk);
    #1;
    chk("s_n", {31'b0, nget >= 3}, 32'd1);
    chk("s_pc0", got_pc[0], 32'h0);
    chk("s_pc1", got_pc[1], 32'h4);
    chk("s_pc2", got_pc[2], 32'h8);
    chk("s_in0", got_ins[0], 32'h13);
    chk("s_in1", got_ins[1], 32'h17);
    chk("s_in2", got_ins[2], 32'h1b);
    chk("s_gap1", got_cyc[1] - got_cyc[0], 32'd2);
    chk("s_gap2", got_cyc[2] - got_cyc[1], 32'd2);
    chk("w_pc0", got2_pc[0], 32'hFFFF_FFF8);
    chk("w_pc1", got2_pc[1], 32'hFFFF_FFFC);
    chk("w_pc2", got2_pc[2], 32'h0000_0000);

    // decode stall fills the queue
    do_reset(1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    chk("st_req", {31'b0, imem_req}, 32'd0);
    chk("st_valid", {31'b0, if_valid}, 32'd1);
    chk("st_pc", if_pc, 32'h0);
    chk("st_instr", if_instr, 32'h13);
    id_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("st_n", {31'b0, nget >= 2}, 32'd1);
    chk("st_pc0", got_pc[0], 32'h0);
    chk("st_pc1", got_pc[1], 32'h4);
    chk("st_in1", got_ins[1], 32'h17);
    chk("st_gap", got_cyc[1] - got_cyc[0], 32'd1);

    // redirect while outstanding, slow memory
    do_reset(3, 1'b1, 1'b1);
    #1;
    chk("rd_req0", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("rd_req1", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("rd_req2", {31'b0, imem_req}, 32'd0);
    chk("rd_valid2", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("rd_req3", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    #1;
    chk("rd_req4", {31'b0, imem_req}, 32'd1);
    chk("rd_addr4", imem_addr, 32'h100);
    repeat (5) @(negedge clk);
    #1;
    chk("rd_n", nget, 32'd1);
    chk("rd_pc", got_pc[0], 32'h100);
    chk("rd_in", got_ins[0], 32'h113);

    // redirect coinciding with response and pop
    do_reset(1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    id_ready = 1'b0;
    #1;
    chk("rc_valid2", {31'b0, if_valid}, 32'd1);
    @(negedge clk);
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    chk("rc_rv", {31'b0, imem_rvalid}, 32'd1);
    chk("rc_valid3", {31'b0, if_valid}, 32'd1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("rc_valid4", {31'b0, if_valid}, 32'd0);
    chk("rc_req4", {31'b0, imem_req}, 32'd1);
    chk("rc_addr4", imem_addr, 32'h200);
    repeat (4) @(negedge clk);
    #1;
    chk("rc_n", nget, 32'd1);
    chk("rc_pc", got_pc[0], 32'h200);

`ifdef FETCH_PERF_EN
    do_reset(1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    chk("pf_cnt", {31'b0, perf >= 32'd5}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("pf_rst", perf, 32'd0);
    imem_ready = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
